// File: rtl/hall_dispatcher.sv
// Group dispatcher for two elevator cars sharing one 7-floor hall panel.
// Latches hall presses, and a scanner visits one call slot per cycle. At that
// slot it assigns an unowned call to the cheaper car, or moves a stale call to
// the other car. A call clears when either car serves it.
module hall_dispatcher #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] hallCall,
  input  logic [2:0]  floorA,
  input  logic [1:0]  directionA,
  input  logic        doorA,
  input  logic [2:0]  floorB,
  input  logic [1:0]  directionB,
  input  logic        doorB,
  output logic [13:0] assignA,
  output logic [13:0] assignB,
  output logic [13:0] pendingCall
);

  // Floor 1 down and floor 7 up do not exist on the panel.
  localparam logic [13:0] SLOT_VALID = 14'h1FFE;
  localparam logic [3:0]  LAST_SLOT  = 4'd13;
  localparam logic [7:0]  AGE_MAX    = 8'hFF;
  localparam logic [7:0]  AGE_LIMIT  = 8'(TIMEOUT);
  localparam logic [3:0]  COST_NONE  = 4'd15;

  // Slot state: pending flag, one-hot ownership (never both), age counter.
  logic [13:0] pending, own_a, own_b;
  logic [7:0]  age [14];
  logic [3:0]  scan_idx;

  logic [13:0] pending_n, own_a_n, own_b_n;
  logic [7:0]  age_n [14];
  logic [3:0]  scan_n;

  logic [13:0] serve;
  logic [3:0]  cost_a [14];
  logic [3:0]  cost_b [14];

  // Floor number (1..7) that slot i belongs to.
  function automatic logic [2:0] slot_floor(input int i);
    return 3'((i >> 1) + 1);
  endfunction

  // Odd slots are up requests, even slots are down requests.
  function automatic logic slot_up(input int i);
    return (i % 2) == 1;
  endfunction

  // A car serves a slot when it stands at the floor with the door open and
  // is either idle or already heading in the requested direction.
  function automatic logic car_serves(input logic [2:0] car_floor,
                                      input logic [1:0] dir,
                                      input logic       door,
                                      input logic [2:0] f,
                                      input logic       up);
    logic dir_ok;
    dir_ok = (dir == 2'b00) || (dir == 2'b11) ||
             (up ? (dir == 2'b10) : (dir == 2'b01));
    return door && (car_floor == f) && dir_ok;
  endfunction

  // Distance to the call floor, plus a fixed 7 penalty when the car would
  // have to reverse or has already passed the floor. Floor 0 means offline.
  function automatic logic [3:0] car_cost(input logic [2:0] car_floor,
                                          input logic [1:0] dir,
                                          input logic [2:0] f,
                                          input logic       up);
    logic signed [4:0] diff;
    logic [3:0]        base;
    logic              compat;
    diff   = $signed({2'b00, car_floor}) - $signed({2'b00, f});
    base   = (diff < 0) ? 4'(-diff) : 4'(diff);
    compat = (dir == 2'b00) || (dir == 2'b11) ||
             ((dir == 2'b10) && (car_floor <= f) && up) ||
             ((dir == 2'b01) && (car_floor >= f) && !up);
    if (car_floor == 3'd0) return COST_NONE;
    return compat ? base : base + 4'd7;
  endfunction

  // Per-slot service detection and cost of each car for that slot.
  always_comb begin
    serve = '0;
    for (int i = 0; i < 14; i++) begin
      serve[i]  = SLOT_VALID[i] &&
                  (car_serves(floorA, directionA, doorA, slot_floor(i), slot_up(i)) ||
                   car_serves(floorB, directionB, doorB, slot_floor(i), slot_up(i)));
      cost_a[i] = car_cost(floorA, directionA, slot_floor(i), slot_up(i));
      cost_b[i] = car_cost(floorB, directionB, slot_floor(i), slot_up(i));
    end
  end

  // Next slot state: service wins over presses and over the scanner decision.
  always_comb begin
    pending_n = pending;
    own_a_n   = own_a;
    own_b_n   = own_b;
    age_n     = age;
    scan_n    = (scan_idx == LAST_SLOT) ? 4'd0 : scan_idx + 4'd1;
    for (int i = 0; i < 14; i++) begin
      if (!SLOT_VALID[i] || serve[i]) begin
        pending_n[i] = 1'b0;
        own_a_n[i]   = 1'b0;
        own_b_n[i]   = 1'b0;
        age_n[i]     = '0;
      end else begin
        pending_n[i] = pending[i] | hallCall[i];
        if ((own_a[i] || own_b[i]) && (age[i] != AGE_MAX))
          age_n[i] = age[i] + 8'd1;
        if ((scan_idx == 4'(i)) && pending[i]) begin
          if (!own_a[i] && !own_b[i]) begin
            // Ties go to car A; with both cars offline the call waits unowned.
            if (!((cost_a[i] == COST_NONE) && (cost_b[i] == COST_NONE))) begin
              own_a_n[i] = (cost_a[i] <= cost_b[i]);
              own_b_n[i] = (cost_a[i] >  cost_b[i]);
            end
            age_n[i] = '0;
          end else if (age[i] >= AGE_LIMIT) begin
            // Stale call: hand it over only if the other car is online.
            if (own_a[i] && (floorB != 3'd0)) begin
              own_a_n[i] = 1'b0;
              own_b_n[i] = 1'b1;
            end else if (own_b[i] && (floorA != 3'd0)) begin
              own_b_n[i] = 1'b0;
              own_a_n[i] = 1'b1;
            end
            age_n[i] = '0;
          end
        end
      end
    end
  end

  // State registers; reset clears every slot and restarts the scan at slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      own_a    <= '0;
      own_b    <= '0;
      scan_idx <= '0;
      for (int i = 0; i < 14; i++) age[i] <= '0;
    end else begin
      pending  <= pending_n;
      own_a    <= own_a_n;
      own_b    <= own_b_n;
      scan_idx <= scan_n;
      for (int i = 0; i < 14; i++) age[i] <= age_n[i];
    end
  end

  assign assignA     = own_a;
  assign assignB     = own_b;
  assign pendingCall = pending;

endmodule

// File: tb/tb_hall_dispatcher.sv
// Bench for hall_dispatcher: a slot-level model of the dispatch rules is
// compared with the DUT every cycle, and directed scenarios add literal checks.
module tb_hall_dispatcher;

  localparam int TO = 8;

  logic        clk;
  logic        reset;
  logic [13:0] hallCall;
  logic [2:0]  floorA, floorB;
  logic [1:0]  directionA, directionB;
  logic        doorA, doorB;
  logic [13:0] assignA, assignB, pendingCall;

  int errors = 0;
  int checks = 0;

  hall_dispatcher #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .hallCall(hallCall),
    .floorA(floorA), .directionA(directionA), .doorA(doorA),
    .floorB(floorB), .directionB(directionB), .doorB(doorB),
    .assignA(assignA), .assignB(assignB), .pendingCall(pendingCall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 car A, 2 car B
  int m_pend [14];
  int m_own  [14];
  int m_age  [14];
  int m_scan;

  function automatic bit valid_slot(input int s);
    return (s >= 1) && (s <= 12);
  endfunction

  function automatic int mcost(input int fl, input int dr, input int s);
    int f;
    int d;
    bit up;
    bit ok;
    f  = s / 2 + 1;
    up = (s % 2) == 1;
    if (fl == 0) return 15;
    d  = (fl > f) ? fl - f : f - fl;
    ok = (dr == 0) || (dr == 3) || (dr == 2 && fl <= f && up) ||
         (dr == 1 && fl >= f && !up);
    return ok ? d : d + 7;
  endfunction

  function automatic bit mserves(input int fl, input int dr, input int door, input int s);
    int f;
    bit up;
    f  = s / 2 + 1;
    up = (s % 2) == 1;
    if (door == 0 || fl != f) return 0;
    return (dr == 0) || (dr == 3) || (up && dr == 2) || (!up && dr == 1);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 14; s++) begin
      m_pend[s] = 0;
      m_own[s]  = 0;
      m_age[s]  = 0;
    end
    m_scan = 0;
  endtask

  task automatic model_step();
    bit srv [14];
    int v;
    int ca, cb;
    int dec_owner;
    bit dec;
    for (int s = 0; s < 14; s++)
      srv[s] = valid_slot(s) &&
               (mserves(int'(floorA), int'(directionA), int'(doorA), s) ||
                mserves(int'(floorB), int'(directionB), int'(doorB), s));
    v = m_scan;
    dec = 0;
    dec_owner = 0;
    if (valid_slot(v) && m_pend[v] != 0 && !srv[v]) begin
      if (m_own[v] == 0) begin
        ca = mcost(int'(floorA), int'(directionA), v);
        cb = mcost(int'(floorB), int'(directionB), v);
        if (ca == 15 && cb == 15) dec_owner = 0;
        else dec_owner = (ca <= cb) ? 1 : 2;
        dec = 1;
      end else if (m_age[v] >= TO) begin
        if (m_own[v] == 1) dec_owner = (floorB != 0) ? 2 : 1;
        else               dec_owner = (floorA != 0) ? 1 : 2;
        dec = 1;
      end
    end
    for (int s = 0; s < 14; s++)
      if (m_own[s] != 0 && m_age[s] < 255) m_age[s]++;
    if (dec) begin
      m_own[v] = dec_owner;
      m_age[v] = 0;
    end
    for (int s = 0; s < 14; s++)
      if (valid_slot(s) && hallCall[s]) m_pend[s] = 1;
    for (int s = 0; s < 14; s++)
      if (srv[s]) begin
        m_pend[s] = 0;
        m_own[s]  = 0;
        m_age[s]  = 0;
      end
    m_scan = (m_scan + 1) % 14;
  endtask

  function automatic logic [13:0] model_vec(input int kind);
    logic [13:0] v;
    v = '0;
    for (int s = 0; s < 14; s++)
      case (kind)
        0: v[s] = (m_pend[s] != 0);
        1: v[s] = (m_own[s] == 1);
        default: v[s] = (m_own[s] == 2);
      endcase
    return v;
  endfunction

  function automatic logic [13:0] dut_vec(input int kind);
    case (kind)
      0: return pendingCall;
      1: return assignA;
      default: return assignB;
    endcase
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model advances on the same edges as the DUT, including async reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model_pending", pendingCall, model_vec(0));
      check("model_assignA", assignA, model_vec(1));
      check("model_assignB", assignB, model_vec(2));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_bit(input int kind, input int b, input int budget, input string name);
    bit hit;
    logic [13:0] v;
    hit = 0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      v = dut_vec(kind);
      if (v[b]) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: bit %0d still 0 after %0d cycles, required 1", name, b, budget);
    end
  endtask

  task automatic press(input int b);
    hallCall = 14'h0;
    hallCall[b] = 1'b1;
    @(negedge clk);
    hallCall = 14'h0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_pend", pendingCall, 14'h0);
    check("rst_assA", assignA, 14'h0);
    check("rst_assB", assignB, 14'h0);
    reset = 1'b0;
  endtask

  logic [13:0] t;

  initial begin
    reset = 1'b1;
    hallCall = 14'h3FFF;
    floorA = 3'd1; directionA = 2'b00; doorA = 1'b0;
    floorB = 3'd7; directionB = 2'b00; doorB = 1'b0;

    // Reset with every button held: outputs stay clear.
    repeat (3) begin
      @(negedge clk);
      check("reset_pending", pendingCall, 14'h0);
      check("reset_assignA", assignA, 14'h0);
      check("reset_assignB", assignB, 14'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    hallCall = 14'h0;
    check("latch_mask", pendingCall, 14'h1FFE);

    // Nearest car: A at 1, B at 7, floor 5 up goes to B.
    do_reset();
    floorA = 3'd1; floorB = 3'd7;
    hallCall = 14'h0200;
    @(negedge clk);
    hallCall = 14'h0;
    t = pendingCall;
    check("near_pending9", {13'h0, t[9]}, 14'h1);
    wait_bit(2, 9, 14, "near_assignB9");
    t = assignA;
    check("near_assignA9", {13'h0, t[9]}, 14'h0);

    // Service by A at floor 5 beats both B's ownership and a new press.
    floorA = 3'd5; doorA = 1'b1; directionA = 2'b00;
    hallCall = 14'h0200;
    @(negedge clk);
    hallCall = 14'h0; doorA = 1'b0;
    t = pendingCall;
    check("srv_pending9", {13'h0, t[9]}, 14'h0);
    t = assignB;
    check("srv_assignB9", {13'h0, t[9]}, 14'h0);
    @(negedge clk);
    t = pendingCall;
    check("srv_press_dropped", {13'h0, t[9]}, 14'h0);
    floorA = 3'd1;

    // Direction penalty: A at 3 going down, B at 3 idle, floor 4 up -> B.
    do_reset();
    floorA = 3'd3; directionA = 2'b01;
    floorB = 3'd3; directionB = 2'b00;
    press(7);
    wait_bit(2, 7, 14, "dir_assignB7");
    t = assignA;
    check("dir_assignA7", {13'h0, t[7]}, 14'h0);
    // Tie at cost 1: floor 2 down -> A.
    directionA = 2'b00;
    press(2);
    wait_bit(1, 2, 14, "tie_assignA2");
    t = assignB;
    check("tie_assignB2", {13'h0, t[2]}, 14'h0);

    // Timeout: floor 2 up goes to A (cost 1 vs 5), then moves to B.
    do_reset();
    floorA = 3'd1; directionA = 2'b00;
    floorB = 3'd7; directionB = 2'b00;
    press(3);
    wait_bit(1, 3, 14, "to_assignA3");
    wait_bit(2, 3, TO + 14, "to_moved_B3");
    t = assignA;
    check("to_left_A3", {13'h0, t[3]}, 14'h0);
    // Both cars offline: B keeps the call across several timeout visits.
    floorA = 3'd0; floorB = 3'd0;
    repeat (40) @(negedge clk);
    t = assignB;
    check("to_kept_B3", {13'h0, t[3]}, 14'h1);
    t = pendingCall;
    check("to_kept_pend3", {13'h0, t[3]}, 14'h1);

    // Both unavailable: call waits unowned until a car comes online.
    do_reset();
    floorA = 3'd0; floorB = 3'd0;
    press(4);
    repeat (40) @(negedge clk);
    t = pendingCall;
    check("off_pending4", {13'h0, t[4]}, 14'h1);
    check("off_assignA", assignA, 14'h0);
    check("off_assignB", assignB, 14'h0);
    floorA = 3'd2;
    wait_bit(1, 4, 14, "off_late_assignA4");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
